// File: rtl/instr_fetch_unit.sv
// Fetch stage: issues imem word requests, buffers in-order responses, feeds decode.
// Optional FETCH_MISALIGN_TRAP_EN halts fetch on a misaligned redirect target.
module instr_fetch_unit #(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int                FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [DATA_W-1:0] imem_rsp_data,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic              fetch_misaligned,
`endif
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc
);

    localparam int PW     = $clog2(FIFO_DEPTH);
    localparam int CW     = PW + 1;
    localparam int DISC_W = CW + 4;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

    typedef enum logic {FETCH, HALT} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   fetch_pc;
    logic [CW-1:0]       inflight;
    logic [CW-1:0]       count;
    logic [DISC_W-1:0]   discard;
    logic [PW-1:0]       head, tail;
    logic [PW-1:0]       pq_head, pq_tail;
    logic [DATA_W-1:0]   data_mem [FIFO_DEPTH];
    logic [ADDR_W-1:0]   pc_mem   [FIFO_DEPTH];
    logic [ADDR_W-1:0]   pq_mem   [FIFO_DEPTH];

    logic [CW:0]         used;
    logic                req_fire;
    logic                push;
    logic                pop;
    logic [ADDR_W-1:0]   target;

    // Credits cover both buffered and outstanding words, so a push never sees a full FIFO.
    assign used           = {1'b0, inflight} + {1'b0, count};
    assign imem_req_valid = !rst && state == FETCH && !redirect_valid && used < DEPTH_C;
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign push           = imem_rsp_valid && discard == '0 && !redirect_valid;
    assign pop            = inst_valid && inst_ready && !redirect_valid;

    assign inst_valid = count != '0;
    assign inst_data  = data_mem[head];
    assign inst_pc    = pc_mem[head];

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned = redirect_pc[1:0] != 2'b00;
    assign target     = redirect_pc;
`else
    assign target     = redirect_pc & ~ADDR_W'(3);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= FETCH;
            fetch_pc <= RESET_PC;
            inflight <= '0;
            count    <= '0;
            discard  <= '0;
            head     <= '0;
            tail     <= '0;
            pq_head  <= '0;
            pq_tail  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                data_mem[i] <= '0;
                pc_mem[i]   <= '0;
                pq_mem[i]   <= '0;
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            fetch_misaligned <= 1'b0;
`endif
        end else if (redirect_valid) begin
            // Everything still owed by memory becomes discard; a same-cycle response is one of them.
            fetch_pc <= target;
            discard  <= discard + DISC_W'(inflight) - DISC_W'(imem_rsp_valid);
            inflight <= '0;
            count    <= '0;
            head     <= '0;
            tail     <= '0;
            pq_head  <= '0;
            pq_tail  <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
            state            <= misaligned ? HALT : FETCH;
            fetch_misaligned <= misaligned;
`else
            state <= FETCH;
`endif
        end else begin
            if (req_fire) begin
                fetch_pc        <= fetch_pc + ADDR_W'(4);
                pq_mem[pq_tail] <= fetch_pc;
                pq_tail         <= pq_tail + PW'(1);
            end
            if (imem_rsp_valid) begin
                if (discard != '0) begin
                    discard <= discard - DISC_W'(1);
                end else begin
                    data_mem[tail] <= imem_rsp_data;
                    pc_mem[tail]   <= pq_mem[pq_head];
                    tail           <= tail + PW'(1);
                    pq_head        <= pq_head + PW'(1);
                end
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            inflight <= inflight + CW'(req_fire) - CW'(push);
            count    <= count + CW'(push) - CW'(pop);
        end
    end

endmodule
